// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding and baud divisor arithmetic.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

   localparam int UART_CLK_FREQ = 50_000_000;
   localparam int UART_BAUD     = 115200;

   // Clock cycles per oversample tick, rounded to nearest.
   function automatic int baud_div(int clk, int baud, int os);
      int den;
      den = baud * os;
      return (clk + den / 2) / den;
   endfunction

endpackage

// File: rtl/baud_gen.sv
// Free-running divisor counter; s_tick is high for one cycle every DIV cycles.
module baud_gen #(
   parameter int DIV = 27
) (
   input  logic ckht,
   input  logic rst,
   output logic s_tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge ckht) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign s_tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, LSB first, 1 start / DATA_SIZE data / 1 stop bit.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_SIZE  = 8,
   parameter int CLK_FREQ   = UART_CLK_FREQ,
   parameter int BAUD       = UART_BAUD,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 ckht,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 fifo_full,
   output logic [DATA_SIZE-1:0] rx_dout,
   output logic                 rx_done_tick,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun
);

   localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int NW  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
   localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DATA_SIZE - 1);

   logic                 s_tick;
   logic                 rx_p0, rx_s;
   rx_state_t            state, state_n;
   logic [SW-1:0]        s, s_n;
   logic [NW-1:0]        n, n_n;
   logic [DATA_SIZE-1:0] b, b_n;
   logic [DATA_SIZE-1:0] dout_r, dout_n;
   logic                 done_r, done_n;
   logic                 ferr_r, ferr_n;
   logic                 ovr_r, ovr_n;
`ifdef UART_RX_PARITY_EN
   logic                 pbad, pbad_n;
   logic                 perr_r, perr_n;
`endif

   baud_gen #(.DIV(DIV)) u_baud_gen (
      .ckht   (ckht),
      .rst    (rst),
      .s_tick (s_tick)
   );

   // Stage boundary: two-flop synchroniser, idles at the line's mark level
   always_ff @(posedge ckht) begin
      if (rst) begin
         rx_p0 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_s  <= rx_p0;
      end
   end

   // Stage boundary: FSM state, counters, shift register and registered pulses
   always_ff @(posedge ckht) begin
      if (rst) begin
         state  <= IDLE;
         s      <= '0;
         n      <= '0;
         b      <= '0;
         dout_r <= '0;
         done_r <= 1'b0;
         ferr_r <= 1'b0;
         ovr_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pbad   <= 1'b0;
         perr_r <= 1'b0;
`endif
      end else begin
         state  <= state_n;
         s      <= s_n;
         n      <= n_n;
         b      <= b_n;
         dout_r <= dout_n;
         done_r <= done_n;
         ferr_r <= ferr_n;
         ovr_r  <= ovr_n;
`ifdef UART_RX_PARITY_EN
         pbad   <= pbad_n;
         perr_r <= perr_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      s_n     = s;
      n_n     = n;
      b_n     = b;
      dout_n  = dout_r;
      done_n  = 1'b0;
      ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_n  = pbad;
      perr_n  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               s_n     = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s == S_MID) begin
                  // A start bit that is high again at its centre was a glitch
                  if (!rx_s) begin
                     state_n = DATA;
                     s_n     = '0;
                     n_n     = '0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  s_n = s + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s == S_LAST) begin
                  b_n = {rx_s, b[DATA_SIZE-1:1]};
                  s_n = '0;
                  if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_n = PARITY;
`else
                     state_n = STOP;
`endif
                  end else begin
                     n_n = n + 1'b1;
                  end
               end else begin
                  s_n = s + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (s_tick) begin
               if (s == S_LAST) begin
                  pbad_n  = (rx_s != ^b);
                  state_n = STOP;
                  s_n     = '0;
               end else begin
                  s_n = s + 1'b1;
               end
            end
         end
`endif
         STOP: begin
            if (s_tick) begin
               if (s == S_LAST) begin
                  if (!rx_s) begin
                     ferr_n  = 1'b1;
                     state_n = BREAK;
                  end else begin
                     state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                     if (pbad) begin
                        perr_n = 1'b1;
                     end else begin
                        done_n = 1'b1;
                        dout_n = b;
                     end
`else
                     done_n = 1'b1;
                     dout_n = b;
`endif
                  end
               end else begin
                  s_n = s + 1'b1;
               end
            end
         end
         BREAK: begin
            if (rx_s) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      ovr_n = done_n & fifo_full;
   end

   always_comb begin
      rx_dout      = dout_r;
      rx_done_tick = done_r;
      frame_err    = ferr_r;
      overrun      = ovr_r;
`ifdef UART_RX_PARITY_EN
      parity_err   = perr_r;
`else
      parity_err   = 1'b0;
`endif
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the DE-10 Lite UART path. It oversamples the asynchronous `rx` pin with an internal baud-tick generator and de-serialises LSB-first frames (1 start bit, DATA_SIZE data bits, optional even parity, 1 stop bit). Each good word is presented on `rx_dout` with a one-cycle `rx_done_tick` that drives `wr` and `wr_data` of `fifo_rx` directly downstream. Line errors are reported as single-cycle pulses.

## Interface
- `DATA_SIZE`, 8: data bits per frame; must equal the downstream FIFO word width.
- `CLK_FREQ`, 50_000_000: `ckht` frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `OVERSAMPLE`, 16: ticks per bit. Must be even and ≥ 8.
- `ckht  in  1`: system clock; the only clock in the block.
- `rst  in  1`: synchronous, active-high reset, sampled on `posedge ckht`.
- `rx  in  1`: asynchronous serial line; idles high.
- `fifo_full  in  1`: `full` from `fifo_rx`; used only for overrun reporting.
- `rx_dout  out  DATA_SIZE`: last received word; feeds `wr_data`.
- `rx_done_tick  out  1`: one-cycle strobe when a word is valid; feeds `wr`.
- `frame_err  out  1`: one-cycle pulse when the stop bit is sampled low.
- `parity_err  out  1`: one-cycle pulse on a parity mismatch. Tied to 0 when parity is compiled out.
- `overrun  out  1`: one-cycle pulse, coincident with `rx_done_tick`, when `fifo_full` is 1.

## Operation
- **Input synchroniser.** Two flops on `rx`; both reset to 1. All logic uses the synchronised `rx_s`.
- **Baud tick.** DIV = round(CLK_FREQ / (BAUD × OVERSAMPLE)); 27 at the default settings. A free-running counter counts 0..DIV-1 and emits `s_tick` for one cycle at DIV-1. Reset clears the counter to 0.
- **FSM.** States: IDLE, START, DATA, PARITY, STOP, BREAK. Registers: tick count `s` (log2 OVERSAMPLE bits), bit count `n` (clog2 DATA_SIZE bits), shift register `b`. Counters advance only on `s_tick`.
  - **IDLE.** `rx_s == 0` → START, `s = 0`.
  - **START.** At `s == OVERSAMPLE/2-1`:
    - `rx_s == 0` → DATA, `s = 0`, `n = 0`.
    - `rx_s == 1` → IDLE (glitch rejected, no pulse).
  - **DATA.** At `s == OVERSAMPLE-1`: set `b = {rx_s, b[DATA_SIZE-1:1]}` and `s = 0`.
    - If `n == DATA_SIZE-1` → PARITY if parity is enabled, otherwise STOP.
    - Else `n++`.
  - **PARITY.** At `s == OVERSAMPLE-1`: latch the mismatch `rx_s != ^b`, then → STOP with `s = 0`.
  - **STOP.** At `s == OVERSAMPLE-1`:
    - `rx_s == 1` and no parity mismatch → `rx_done_tick`, `rx_dout = b`, IDLE.
    - `rx_s == 1` with a parity mismatch → `parity_err` pulse, no `rx_done_tick`, `rx_dout` unchanged, IDLE.
    - `rx_s == 0` → `frame_err` pulse, no `rx_done_tick`, BREAK. The framing error takes precedence over parity.
  - **BREAK.** Wait for `rx_s == 1`, then → IDLE. A held-low line never yields words.
- **Overrun.** `overrun = rx_done_tick & fifo_full`. The word is still strobed; `fifo_rx` discards it.
- **Reset.** `rst` at any time, including mid-frame, returns the block to IDLE. `s`, `n`, `b` and `rx_dout` go to 0; all pulse outputs go to 0; the synchroniser goes to 1. The partial frame is dropped without any error pulse.

## Timing
- Reset values: `rx_dout = 0`; `rx_done_tick = frame_err = parity_err = overrun = 0`.
- All outputs are registered. `rx_done_tick`, `frame_err` and `parity_err` are high for exactly one `ckht` cycle, in the cycle after the deciding `s_tick`.
- `rx_dout` changes only in the cycle in which `rx_done_tick` is high, and holds until the next good word.
- Latency from the synchronised falling edge to `rx_done_tick`:
  - 8N1: OVERSAMPLE/2 + (DATA_SIZE+1)·OVERSAMPLE ticks, i.e. 152 ticks, then +1 cycle. The pin adds 2 synchroniser cycles.
  - With parity: +OVERSAMPLE ticks.
- Back-to-back frames with no idle gap are supported: a start edge immediately after the stop sample is accepted from IDLE.
- The sample point has ≤ 1 tick of phase error, because the baud counter is not re-aligned to the start edge.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state is present and the frame length is DATA_SIZE+3 bits.
  - A mismatch suppresses `rx_done_tick` and pulses `parity_err`.
- `UART_RX_PARITY_EN` undefined:
  - The PARITY state and its logic are not compiled.
  - `parity_err` is constant 0 and the frame is 8N1.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [2:0] rx_state_t` with values IDLE, START, DATA, PARITY, STOP, BREAK.
  - `function int baud_div(int clk, int baud, int os)`.
  - Default constants `UART_CLK_FREQ` and `UART_BAUD`.
- One sub-module, `baud_gen`: the divisor counter producing `s_tick`, reusable by the TX side.

## Test plan
- **Good byte.** Send 0xA5 8N1 after reset → exactly one `rx_done_tick`, `rx_dout = 0xA5`, 152 ticks (±1) after the start edge. Error outputs stay 0.
- **Glitch rejection.** Drive `rx` low for 4 ticks, then high → no pulses, FSM back in IDLE; a following 0x3C is received correctly.
- **Framing error and break.**
  - Frame 0x55 with the stop bit low, then hold the line low for 3 bit times → one `frame_err`, no `rx_done_tick`, `rx_dout` unchanged.
  - Release the line, then send 0x81 → `rx_dout = 0x81`.
- **Back-to-back and overrun.** Send 0x00 then 0xFF with zero gap while `fifo_full = 1` → two `rx_done_tick`, each with a coincident `overrun` pulse; data 0x00 then 0xFF.
- **Reset mid-frame.** Assert `rst` for 1 cycle during data bit 3 → all outputs 0, no pulses; the next frame 0x7E is received correctly.
- **Parity (with `UART_RX_PARITY_EN`).**
  - 0x0F with parity bit 0 → `rx_done_tick`.
  - 0x0F with parity bit 1 → `parity_err` only.
